// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard/sequencing controller:
//   - FSM state encoding (INIT, RUN, MEM_WAIT, ERROR)
//   - default register-index width
//   - bit positions and canned patterns of the packed hazard-control vector
//     {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
// No ports (package).
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } hc_state_t;

    localparam int HC_W      = 7;
    localparam int HC_STALLF = 6;
    localparam int HC_STALLD = 5;
    localparam int HC_STALLE = 4;
    localparam int HC_STALLM = 3;
    localparam int HC_FLUSHD = 2;
    localparam int HC_FLUSHE = 1;
    localparam int HC_FLUSHW = 0;

    typedef logic [HC_W-1:0] hc_vec_t;

    // One-hot helper so the canned patterns below read as lists of enables
    function automatic hc_vec_t hcBit(input int pos);
        hc_vec_t v;
        v      = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

    // Post-reset drain: hold PC and push bubbles through every stage register
    localparam hc_vec_t HC_INIT    = hcBit(HC_STALLF) | hcBit(HC_FLUSHD) |
                                     hcBit(HC_FLUSHE) | hcBit(HC_FLUSHW);
    // Memory not ready: everything up to MEM holds, WB receives a bubble
    localparam hc_vec_t HC_FREEZE  = hcBit(HC_STALLF) | hcBit(HC_STALLD) |
                                     hcBit(HC_STALLE) | hcBit(HC_STALLM) |
                                     hcBit(HC_FLUSHW);
    localparam hc_vec_t HC_BRANCH  = hcBit(HC_FLUSHD) | hcBit(HC_FLUSHE);
    localparam hc_vec_t HC_LOADUSE = hcBit(HC_STALLF) | hcBit(HC_STALLD) |
                                     hcBit(HC_FLUSHE);

endpackage

// File: rtl/hazard_ctrl_priority.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_priority
// Purely combinational RUN-state hazard evaluation, priority
// freeze > branch flush > load-use stall. Shared by the RUN state and the
// MEM_WAIT release path of hazard_ctrl.
// Ports:
//   i_memReadE          EX-stage instruction is a load
//   i_rdE               EX-stage destination register
//   i_rs1D, i_rs2D      Decode-stage source registers
//   i_pcSrcE            taken branch/jump resolved in EX
//   i_memReqM           MEM stage has a valid data-memory access
//   i_memReadyM         data memory completes the access this cycle
//   o_ctrl              packed hazard-control vector (see hazard_ctrl_pkg)
//   o_freeze            memory freeze condition is active
// ---------------------------------------------------------------------------
module hazard_ctrl_priority
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  i_memReadE,
    input  logic [REG_ADDR_W-1:0] i_rdE,
    input  logic [REG_ADDR_W-1:0] i_rs1D,
    input  logic [REG_ADDR_W-1:0] i_rs2D,
    input  logic                  i_pcSrcE,
    input  logic                  i_memReqM,
    input  logic                  i_memReadyM,
    output hc_vec_t               o_ctrl,
    output logic                  o_freeze
);

    logic w_loadUse;

    // x0 is hard-wired zero, so a load "into" it never creates a dependency
    assign w_loadUse = i_memReadE && (i_rdE != '0) &&
                       ((i_rdE == i_rs1D) || (i_rdE == i_rs2D));

    assign o_freeze = i_memReqM && !i_memReadyM;

    // A taken branch squashes the Decode instruction, so any load-use it
    // would have caused is irrelevant and the branch wins
    always_comb begin
        o_ctrl = '0;
        if (o_freeze) begin
            o_ctrl = HC_FREEZE;
        end else if (i_pcSrcE) begin
            o_ctrl = HC_BRANCH;
        end else if (w_loadUse) begin
            o_ctrl = HC_LOADUSE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Sequencing controller for the 5-stage RISC-V pipeline. Drives stall and
// flush enables (Mealy, same-cycle), drains the pipeline after reset, freezes
// on data-memory wait and flags a sticky error on memory timeout.
// Optional macro HAZARD_CTRL_PERF_EN adds StallCnt/FlushCnt counters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   MemReadE, RDE            EX-stage load flag and destination register
//   RS1D, RS2D               Decode-stage sources
//   PCSrcE                   taken branch/jump in EX
//   MemReqM, MemReadyM       MEM-stage request and memory-ready
//   StallF/D/E/M             stage-register hold enables
//   FlushD/E/W               stage-register bubble enables
//   MemErr                   sticky memory-timeout error
//   StallCnt, FlushCnt       (HAZARD_CTRL_PERF_EN only) event counters
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int INIT_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadE,
    input  logic [REG_ADDR_W-1:0] RDE,
    input  logic [REG_ADDR_W-1:0] RS1D,
    input  logic [REG_ADDR_W-1:0] RS2D,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  MemErr
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]           StallCnt,
    output logic [31:0]           FlushCnt
`endif
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYCLES);

    hc_state_t         r_state;
    hc_state_t         w_nextState;
    logic [INIT_W-1:0] r_initCnt;
    logic [WAIT_W-1:0] r_waitCnt;
    hc_vec_t           w_runCtrl;
    hc_vec_t           w_ctrl;
    logic              w_runFreeze;
    logic              w_release;

    hazard_ctrl_priority #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_priority (
        .i_memReadE  (MemReadE),
        .i_rdE       (RDE),
        .i_rs1D      (RS1D),
        .i_rs2D      (RS2D),
        .i_pcSrcE    (PCSrcE),
        .i_memReqM   (MemReqM),
        .i_memReadyM (MemReadyM),
        .o_ctrl      (w_runCtrl),
        .o_freeze    (w_runFreeze)
    );

    // The wait ends either because memory answered or the request vanished
    assign w_release = MemReadyM || !MemReqM;

    // Output and next-state selection; the release cycle of MEM_WAIT behaves
    // exactly like a RUN cycle so hazards pending behind the freeze resolve
    // without losing a cycle
    always_comb begin
        w_ctrl      = HC_INIT;
        w_nextState = r_state;
        case (r_state)
            ST_INIT: begin
                w_ctrl = HC_INIT;
                if (r_initCnt == INIT_LAST) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ctrl = w_runCtrl;
                if (w_runFreeze) begin
                    w_nextState = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (w_release) begin
                    w_ctrl      = w_runCtrl;
                    w_nextState = ST_RUN;
                end else begin
                    w_ctrl = HC_FREEZE;
                    if (r_waitCnt == WAIT_MAX) begin
                        w_nextState = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                w_ctrl = HC_FREEZE;
            end
            default: begin
                w_ctrl      = HC_INIT;
                w_nextState = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Counts drain cycles; only meaningful while in INIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_initCnt <= '0;
        end else if (r_state == ST_INIT && r_initCnt != INIT_LAST) begin
            r_initCnt <= r_initCnt + INIT_W'(1);
        end
    end

    // Counts consecutive wait cycles; the freezing RUN cycle counts as the
    // first, and the value saturates instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_waitCnt <= w_runFreeze ? WAIT_W'(1) : '0;
        end else if (r_state == ST_MEM_WAIT) begin
            if (w_release) begin
                r_waitCnt <= '0;
            end else if (r_waitCnt != WAIT_MAX) begin
                r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    // In RUN only a branch flush raises FlushD, so it marks a branch cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if ((r_state == ST_RUN || r_state == ST_MEM_WAIT) && w_ctrl[HC_STALLF]) begin
                StallCnt <= StallCnt + 32'd1;
            end
            if (r_state == ST_RUN && w_runCtrl[HC_FLUSHD]) begin
                FlushCnt <= FlushCnt + 32'd1;
            end
        end
    end
`endif

    assign StallF = w_ctrl[HC_STALLF];
    assign StallD = w_ctrl[HC_STALLD];
    assign StallE = w_ctrl[HC_STALLE];
    assign StallM = w_ctrl[HC_STALLM];
    assign FlushD = w_ctrl[HC_FLUSHD];
    assign FlushE = w_ctrl[HC_FLUSHE];
    assign FlushW = w_ctrl[HC_FLUSHW];
    assign MemErr = (r_state == ST_ERROR);

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Sequencing controller for the 5-stage RISC-V pipeline; sits beside the forwarding hazard unit and drives stage-register stall and flush enables.
- Resolves load-use stalls and taken-branch flushes, and freezes the whole pipeline while data memory is not ready.
- Sequences a post-reset pipeline drain and detects data-memory timeouts.

Parameters:
- REG_ADDR_W, 5, register index width.
- INIT_CYCLES, 2, cycles of pipeline flush after reset release; must be ≥ 1.
- TIMEOUT_CYCLES, 16, consecutive memory-wait cycles tolerated before error; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemReadE  in  1  EX-stage instruction is a load.
- RDE  in  REG_ADDR_W  EX-stage destination register.
- RS1D  in  REG_ADDR_W  Decode-stage source 1.
- RS2D  in  REG_ADDR_W  Decode-stage source 2.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- MemReqM  in  1  MEM stage has a valid data-memory access.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- StallE  out  1  hold ID/EX register.
- StallM  out  1  hold EX/MEM register.
- FlushD  out  1  bubble into IF/ID.
- FlushE  out  1  bubble into ID/EX.
- FlushW  out  1  bubble into MEM/WB.
- MemErr  out  1  sticky memory-timeout error.

Behaviour:
- Clocking and reset: clk is the only clock; rst is asynchronous and active-high. Reset forces state INIT, init counter 0 and wait counter 0.
- Output style: all outputs are combinational from state and inputs (Mealy), so they take effect in the same cycle.
- Reset output values (INIT): StallF=1, FlushD=1, FlushE=1, FlushW=1; StallD, StallE, StallM and MemErr = 0.
- INIT state:
  - Outputs as above.
  - The init counter increments each cycle.
  - Move to RUN on the edge where the counter equals INIT_CYCLES-1, giving exactly INIT_CYCLES flush cycles.
  - All data inputs are ignored.
- RUN state, outputs are evaluated in this priority order:
  1. Freeze, when MemReqM && !MemReadyM:
     - StallF, StallD, StallE and StallM = 1; FlushW = 1; all other outputs 0.
     - Branch and load-use are suppressed.
     - Next state is MEM_WAIT and the wait counter is set to 1.
  2. Branch, when PCSrcE:
     - FlushD = 1 and FlushE = 1.
     - A simultaneous load-use is ignored because the Decode instruction is squashed.
  3. Load-use, when MemReadE && RDE != 0 && (RDE == RS1D || RDE == RS2D):
     - StallF = 1, StallD = 1, FlushE = 1, for exactly one cycle.
     - The next cycle re-evaluates with the bubble now in EX.
  4. Otherwise: all outputs 0.
- MEM_WAIT state:
  - If MemReadyM = 1 or MemReqM = 0: outputs are the RUN evaluation for this cycle (release), the wait counter clears, and the next state is RUN.
  - Otherwise the freeze outputs are held and the wait counter increments.
  - If the counter already equals TIMEOUT_CYCLES, go to ERROR instead.
  - The counter width is clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.
- ERROR state:
  - StallF, StallD, StallE and StallM = 1; FlushW = 1; MemErr = 1.
  - Left only by rst.
- Reset mid-operation: asserting rst in any state returns asynchronously to INIT with the reset output values above.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- Enabled:
  - Adds outputs StallCnt[31:0] and FlushCnt[31:0], both 0 on reset.
  - StallCnt increments each RUN or MEM_WAIT cycle where StallF = 1.
  - FlushCnt increments each RUN cycle with a branch flush.
  - Both counters wrap at 2^32 and do not count in INIT or ERROR.
- Disabled: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - State encoding enum: INIT=0, RUN=1, MEM_WAIT=2, ERROR=3.
  - REG_ADDR_W default.
  - Bit positions of a packed hazard-control vector {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}.
- Sub-module hazard_ctrl_priority: purely combinational RUN-state evaluation (freeze/branch/load-use), reused by RUN and the MEM_WAIT release path.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: rst=1 for 20 ns, then release with INIT_CYCLES=2 → FlushD, FlushE, FlushW and StallF are 1 for exactly 2 clocks after release, then all outputs are 0 in RUN.
- Load-use: MemReadE=1, RDE=5'h3, RS1D=5'h3, RS2D=5'h4 for one cycle → StallF=StallD=FlushE=1 that cycle only. Repeat with RDE=5'h0 → no stall.
- Branch vs load-use: PCSrcE=1 together with the load-use inputs above → FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 → freeze outputs for 3 cycles, release in the ready cycle, state returns to RUN, MemErr=0.
- Timeout: TIMEOUT_CYCLES=4, MemReqM=1 and MemReadyM=0 held → MemErr rises after the 5th wait cycle and stays set when MemReadyM later goes to 1; rst clears it to 0.
- Async reset while in MEM_WAIT: assert rst mid-cycle → outputs switch to the INIT values immediately, without waiting for a clk edge.
